button_pulse_conditioner: RTL and testbench
===========================================

Name: button_pulse_conditioner

Overview:
- Conditions the raw push-button input that drives the `select_button` input of the auto-increment counter (+10 per press, wraps after 150).
- Synchronises and debounces the button, then emits a single-cycle `press_pulse` per debounced press.
- When enabled, emits auto-repeat pulses while the button is held.
- Also provides a debounced level, a release pulse and a status LED for the board.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `button_in` (minimum 2).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a press or release (minimum 2). 10 ms at 50 MHz.
- REPEAT_EN, 0, 1 enables auto-repeat while held.
- REPEAT_DELAY, 25000000, cycles held in PRESSED before the first repeat pulse (minimum 2).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (minimum 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- button_in  input  1  raw, asynchronous, bouncing button; 1 = pressed.
- press_pulse  output  1  one-cycle pulse per accepted press or repeat; feeds the counter's `select_button`.
- release_pulse  output  1  one-cycle pulse per accepted release.
- button_level  output  1  debounced button state.
- repeat_active  output  1  high while in the REPEAT state.

Behaviour:
- Reset (asynchronous assert): all synchroniser flops = 0, state = IDLE, cnt = 0, all outputs = 0.
- Synchroniser: `btn_s` is the output of the last stage. The FSM sees only `btn_s`, never `button_in`.
- Counter width: clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1 bits; it never wraps.
- All outputs are registered.
- FSM states and transitions (evaluated each rising edge):
  - IDLE: if `btn_s` = 1, go to DEB_PRESS with cnt = 1.
  - DEB_PRESS: if `btn_s` = 0, go to IDLE with cnt = 0 (bounce rejected, no pulse). Else if cnt = DEBOUNCE_CYCLES-1, go to PRESSED with cnt = 0 and `press_pulse` = 1 for the next cycle. Else cnt++.
  - PRESSED: if `btn_s` = 0, go to DEB_RELEASE with cnt = 1. Else if REPEAT_EN and cnt = REPEAT_DELAY-1, go to REPEAT with cnt = 0 and a pulse. Else cnt++; when REPEAT_EN = 0, cnt saturates.
  - REPEAT: if `btn_s` = 0, go to DEB_RELEASE with cnt = 1. Else if cnt = REPEAT_PERIOD-1, cnt = 0 and pulse. Else cnt++.
  - DEB_RELEASE: if `btn_s` = 1, go to PRESSED with cnt = 0 and no pulse; the repeat phase restarts from REPEAT_DELAY. Else if cnt = DEBOUNCE_CYCLES-1, go to IDLE with `release_pulse` = 1. Else cnt++.
- Output decode:
  - `button_level` = 1 in PRESSED, REPEAT and DEB_RELEASE; 0 otherwise.
  - `repeat_active` = 1 only in REPEAT.
- Press latency: a clean press held from edge 1 gives `press_pulse` high in the cycle following edge SYNC_STAGES + DEBOUNCE_CYCLES. With defaults 2 and N, that is edge N+2.
- Release latency: identical, SYNC_STAGES + DEBOUNCE_CYCLES edges after `button_in` falls.
- Pulse rules:
  - `press_pulse` and `release_pulse` are never both high, and each is never high for more than 1 consecutive cycle.
  - `press_pulse` is never issued without an intervening release, except repeat pulses in REPEAT.
- Reset mid-operation: all state is cleared immediately. A button still held after reset deasserts is treated as a new press: full synchroniser plus debounce delay, then one `press_pulse`.
- Glitch: a high on `button_in` shorter than DEBOUNCE_CYCLES produces no pulse and `button_level` stays 0.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4; 10-unit clock):
1. Reset for 2 cycles, `button_in` = 0 → all outputs 0, state IDLE; hold 20 cycles and no pulse appears.
2. `button_in` high and held from edge 1 → `press_pulse` = 1 only in the cycle after edge 6 and `button_level` = 1 from that cycle. Release → `release_pulse` exactly once, 6 edges later, and `button_level` = 0.
3. Bounce: toggle `button_in` 1,0,1,0 on successive cycles, then hold 1 → exactly one `press_pulse`, 6 edges after the final rise. No pulse comes from the toggles.
4. REPEAT_EN=1, hold 30 cycles → pulses after edges 6, 14, 18, 22, 26, 30 (6 in total). `repeat_active` = 1 from edge 14. Release → `repeat_active` = 0 and one `release_pulse`.
5. Chain to the counter: 15 clean presses → counter reads 150. A 16th press → counter reads 0. One pulse per press is confirmed by counting `press_pulse` = 16.
6. Assert reset mid-DEB_PRESS (after edge 4) while the button stays held → outputs clear asynchronously. After deassert, one `press_pulse` 6 edges later and no `release_pulse`.

Source files
------------

// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner: synchronises and debounces a push button, emitting press/release pulses,
// a debounced level and optional auto-repeat pulses while held.
module button_pulse_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic button_level,
  output logic repeat_active
);
  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYC = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] DEB_PRESS   = 3'd1;
  localparam logic [2:0] PRESSED     = 3'd2;
  localparam logic [2:0] REPEAT      = 3'd3;
  localparam logic [2:0] DEB_RELEASE = 3'd4;
  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_s;
  logic [2:0]             state, state_n;
  logic [CW-1:0]          cnt, cnt_n, cnt_inc;
  logic                   press_n, release_n;
  assign btn_s   = sync[SYNC_STAGES-1];
  // saturating increment so a long hold without repeat never wraps
  assign cnt_inc = &cnt ? cnt : cnt + ONE;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt_inc;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = btn_s ? DEB_PRESS : IDLE;
        cnt_n   = btn_s ? ONE : '0;
      end
      DEB_PRESS:
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          press_n = 1'b1;
        end
      PRESSED:
        if (!btn_s) begin
          state_n = DEB_RELEASE;
          cnt_n   = ONE;
        end else if (REPEAT_EN != 0 && cnt == DLY_LAST) begin
          state_n = REPEAT;
          cnt_n   = '0;
          press_n = 1'b1;
        end
      REPEAT:
        if (!btn_s) begin
          state_n = DEB_RELEASE;
          cnt_n   = ONE;
        end else if (cnt == PER_LAST) begin
          cnt_n   = '0;
          press_n = 1'b1;
        end
      DEB_RELEASE:
        if (btn_s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          release_n = 1'b1;
        end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync          <= '0;
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      button_level  <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], button_in};
      state         <= state_n;
      cnt           <= cnt_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      button_level  <= state_n == PRESSED || state_n == REPEAT || state_n == DEB_RELEASE;
      repeat_active <= state_n == REPEAT;
    end
  end
endmodule

// File: tb/tb_button_pulse_conditioner.sv
// tb_button_pulse_conditioner: two instances (repeat off / on) share one button; checked against
// hand-written vectors and a run-length reference model.
module tb_button_pulse_conditioner;
  localparam int SS = 2, DEB = 4, DLY = 8, PER = 4;
  logic clk = 1'b0, reset = 1'b1, button_in = 1'b0;
  logic [1:0] pp, rp, lv, ra;
  int errors = 0, checks = 0;
  int cnt_val = 0;
  int np[2], nr[2];
  bit q[$];
  int m_run[2], m_h[2];
  bit m_lvl[2], m_pp[2], m_rp[2], m_ra[2];
  typedef struct {bit btn; bit press; bit rel; bit lvl;} vec_t;
  vec_t tbl[16];
  button_pulse_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut0 (
    .clk(clk), .reset(reset), .button_in(button_in), .press_pulse(pp[0]),
    .release_pulse(rp[0]), .button_level(lv[0]), .repeat_active(ra[0]));
  button_pulse_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut1 (
    .clk(clk), .reset(reset), .button_in(button_in), .press_pulse(pp[1]),
    .release_pulse(rp[1]), .button_level(lv[1]), .repeat_active(ra[1]));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    for (int e = 0; e < 2; e++) begin
      m_run[e] = 0; m_h[e] = 0; m_lvl[e] = 0; m_pp[e] = 0; m_rp[e] = 0; m_ra[e] = 0;
    end
  endtask
  // level flips after DEB consecutive samples disagreeing with it; repeats fire at
  // DLY, DLY+PER, ... uninterrupted high samples after acceptance
  task automatic model_edge(input bit b);
    bit s;
    q.push_back(b);
    s = 1'b0;
    if (q.size() > SS) s = q.pop_front();
    for (int e = 0; e < 2; e++) begin
      m_pp[e] = 0; m_rp[e] = 0;
      if (s != m_lvl[e]) begin
        m_run[e]++;
        if (m_run[e] == DEB) begin
          m_lvl[e] = s; m_run[e] = 0; m_h[e] = 0; m_pp[e] = s; m_rp[e] = !s;
        end
      end else begin
        if (m_lvl[e]) begin
          m_h[e] = (m_run[e] > 0) ? 0 : m_h[e] + 1;
          if (e == 1 && m_h[e] >= DLY && (m_h[e] - DLY) % PER == 0) m_pp[e] = 1;
        end
        m_run[e] = 0;
      end
      m_ra[e] = e == 1 && m_lvl[e] && m_run[e] == 0 && m_h[e] >= DLY;
    end
  endtask
  task automatic step(input bit b);
    button_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
    for (int e = 0; e < 2; e++) begin
      chk($sformatf("model_press%0d", e), pp[e], m_pp[e]);
      chk($sformatf("model_release%0d", e), rp[e], m_rp[e]);
      chk($sformatf("model_level%0d", e), lv[e], m_lvl[e]);
      chk($sformatf("model_repeat%0d", e), ra[e], m_ra[e]);
      if (pp[e]) np[e]++;
      if (rp[e]) nr[e]++;
    end
    if (pp[0]) cnt_val = (cnt_val == 150) ? 0 : cnt_val + 10;
  endtask
  task automatic chk_zero(input string n);
    for (int e = 0; e < 2; e++)
      chk($sformatf("%s_outs%0d", n, e), {pp[e], rp[e], lv[e], ra[e]}, 0);
  endtask
  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    model_reset();
  endtask
  initial begin
    int b0, b1, r0, r1, first, ps[$];
    int exp_ps[6] = '{6, 14, 18, 22, 26, 30};
    bit b;
    model_reset();
    for (int k = 0; k < 16; k++)
      tbl[k] = '{btn: k <= 7, press: k == 5, rel: k == 13, lvl: k >= 5 && k <= 12};
    // idle after reset
    apply_reset(2);
    b0 = np[0] + np[1] + nr[0] + nr[1];
    repeat (20) step(1'b0);
    chk("idle_pulses", np[0] + np[1] + nr[0] + nr[1] - b0, 0);
    // clean press and release, hand-written expectations
    apply_reset(1);
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].btn);
      chk($sformatf("tbl_press[%0d]", k), pp[0], tbl[k].press);
      chk($sformatf("tbl_release[%0d]", k), rp[0], tbl[k].rel);
      chk($sformatf("tbl_level[%0d]", k), lv[0], tbl[k].lvl);
    end
    // bounce then hold
    apply_reset(1);
    ps.delete();
    for (int k = 1; k <= 17; k++) begin
      step(k <= 4 ? (k % 2 == 1) : 1'b1);
      if (pp[0]) ps.push_back(k);
    end
    chk("bounce_count", ps.size(), 1);
    if (ps.size() > 0) chk("bounce_step", ps[0], 10);
    // auto-repeat while held
    apply_reset(1);
    ps.delete();
    first = 0;
    b0 = np[0];
    for (int k = 1; k <= 30; k++) begin
      step(1'b1);
      if (pp[1]) ps.push_back(k);
      if (ra[1] && first == 0) first = k;
    end
    chk("repeat_count", ps.size(), 6);
    for (int i = 0; i < 6 && i < ps.size(); i++) chk($sformatf("repeat_step[%0d]", i), ps[i], exp_ps[i]);
    chk("repeat_first_active", first, 14);
    chk("norepeat_presses", np[0] - b0, 1);
    r1 = nr[1];
    repeat (10) step(1'b0);
    chk("repeat_release_count", nr[1] - r1, 1);
    chk("repeat_active_after_release", ra[1], 0);
    // counter chain: 16 presses
    apply_reset(1);
    cnt_val = 0;
    b0 = np[0];
    for (int p = 1; p <= 16; p++) begin
      repeat (8) step(1'b1);
      repeat (8) step(1'b0);
      if (p == 15) chk("counter_after_15", cnt_val, 150);
    end
    chk("counter_after_16", cnt_val, 0);
    chk("counter_presses", np[0] - b0, 16);
    // asynchronous reset mid-debounce and mid-press
    apply_reset(1);
    repeat (4) step(1'b1);
    reset = 1'b1;
    #1;
    chk_zero("async_deb");
    #1;
    reset = 1'b0;
    model_reset();
    ps.delete();
    b0 = np[0]; r0 = nr[0]; b1 = np[1]; r1 = nr[1];
    for (int k = 1; k <= 7; k++) begin
      step(1'b1);
      if (pp[0]) ps.push_back(k);
    end
    chk("post_reset_presses", np[0] - b0, 1);
    if (ps.size() > 0) chk("post_reset_step", ps[0], 6);
    chk("post_reset_release", nr[0] - r0 + nr[1] - r1, 0);
    chk("post_reset_level", lv[0], 1);
    reset = 1'b1;
    #1;
    chk_zero("async_pressed");
    #1;
    reset = 1'b0;
    model_reset();
    // randomized runs against the model
    b = 1'b0;
    for (int i = 0; i < 2500;) begin
      int len;
      len = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 40 : 6);
      b = ~b;
      for (int j = 0; j < len; j++) step(b);
      i += len;
      if ($urandom_range(0, 30) == 0) apply_reset(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
